seg7_bus_writer: RTL and testbench

- Bus initiator that updates the 7-segment controller over the shared memory-mapped bus.
- On a start pulse it splits an input value into hex nibbles and writes one nibble to each digit register at BASE_ADDR + i*(DATA_WIDTH/8).
- It then reads every register back, compares against the written nibbles, and reports done, mismatch or timeout.
- Sits between any producer (counter, debug probe, CPU-less demo) and the bus fabric that feeds seg7_controller.

---
 rtl/seg7_bus_writer_pkg.sv | 24 ++
 rtl/seg7_bus_writer_if.sv | 18 +
 rtl/seg7_bus_writer_bus_req_timer.sv | 32 +++
 rtl/seg7_bus_writer.sv | 161 ++++++++++++++++
 tb/tb_seg7_bus_writer.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/seg7_bus_writer_pkg.sv
// Shared types for the 7-segment bus writer: FSM states, phase and byte-stride helper.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package seg7_bus_pkg;

   typedef enum logic [2:0] {
      IDLE,
      WR_REQ,
      RD_REQ,
      GAP,
      FINISH
   } state_t;

   typedef enum logic {
      PH_WRITE,
      PH_READ
   } phase_t;

   // Register stride in bytes for a bus of the given data width.
   function automatic int unsigned byte_stride(input int unsigned data_width);
      return data_width / 8;
   endfunction

endpackage

// File: rtl/seg7_bus_writer_if.sv
// Simple strobe/ack memory-mapped bus between an initiator and a register responder.
// Latency: responder-defined; a request completes in the cycle strobe and ack are both high.
// Backpressure: the initiator holds addr/wdata/strobe stable until ack.
// Signals: addr, wdata, wr, rd (initiator -> responder); ack, rdata (responder -> initiator).
interface seg7_bus_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   logic [ADDR_WIDTH-1:0] addr;
   logic [DATA_WIDTH-1:0] wdata;
   logic                  wr;
   logic                  rd;
   logic                  ack;
   logic [DATA_WIDTH-1:0] rdata;

   modport master (output addr, wdata, wr, rd, input ack, rdata);
   modport slave  (input addr, wdata, wr, rd, output ack, rdata);
endinterface

// File: rtl/seg7_bus_writer_bus_req_timer.sv
// Wait-cycle counter for one outstanding bus request; flags when TIMEOUT cycles are used up.
// Latency: expired is a decode of the registered count, valid the cycle the count reaches TIMEOUT-1.
// Backpressure: none; clr has priority over en, and the count holds once expired.
// Ports: clk, n_rst (async active-low), clr, en, expired.
module bus_req_timer #(
   parameter int unsigned TIMEOUT = 256
) (
   input  logic clk,
   input  logic n_rst,
   input  logic clr,
   input  logic en,
   output logic expired
);

   localparam int unsigned   CW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en && !expired) begin
         cnt <= cnt + CW'(1);
      end
   end

   assign expired = (cnt == LAST);

endmodule

// File: rtl/seg7_bus_writer.sv
// Writes each hex nibble of a captured value to its digit register, reads all back and verifies.
// Latency: 2*NUM_7SEGMENTS*2 + 2 cycles start-to-done with zero-wait acks (34 for 8 digits).
// Backpressure: each request is held until ack; a request unacked for TIMEOUT cycles aborts the run.
// Ports: clk, n_rst, i_start, i_value, o_busy, o_done, o_mismatch, o_error, bus (master side).
module seg7_bus_writer
   import seg7_bus_pkg::*;
#(
   parameter int unsigned           ADDR_WIDTH    = 32,
   parameter int unsigned           DATA_WIDTH    = 32,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR     = 32'hc0001000,
   parameter int unsigned           NUM_7SEGMENTS = 8,
   parameter int unsigned           TIMEOUT       = 256
) (
   input  logic                  clk,
   input  logic                  n_rst,
   input  logic                  i_start,
   input  logic [DATA_WIDTH-1:0] i_value,
   output logic                  o_busy,
   output logic                  o_done,
   output logic                  o_mismatch,
   output logic                  o_error,
   seg7_bus_if.master            bus
);

   // NUM_7SEGMENTS*4 must not exceed DATA_WIDTH: every digit takes one nibble of i_value.
   localparam int unsigned           IW       = (NUM_7SEGMENTS > 1) ? $clog2(NUM_7SEGMENTS) : 1;
   localparam logic [IW-1:0]         LAST_IDX = IW'(NUM_7SEGMENTS - 1);
   localparam logic [ADDR_WIDTH-1:0] STRIDE   = ADDR_WIDTH'(byte_stride(DATA_WIDTH));

   state_t                state_q, state_d;
   phase_t                phase_q;
   logic [IW-1:0]         idx_q;
   logic [DATA_WIDTH-1:0] val_q;
   logic                  mismatch_q;
   logic                  error_q;
   logic                  fin_q;       // read-back of the last digit has completed

   logic                  wr, rd, busy, done;
   logic [3:0]            cur_nib;
   logic [ADDR_WIDTH-1:0] req_addr;
   logic                  tmr_clr, tmr_en, tmr_expired;
   logic                  unused_rdata;

   assign cur_nib  = val_q[4*idx_q +: 4];
   assign req_addr = BASE_ADDR + (ADDR_WIDTH'(idx_q) * STRIDE);   // wraps modulo 2^ADDR_WIDTH

   // Only the low nibble of read data carries a digit.
   assign unused_rdata = ^bus.rdata[DATA_WIDTH-1:4];

   // ---------------- state register ----------------
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ---------------- next state and outputs ----------------
   always_comb begin
      state_d = state_q;
      wr      = 1'b0;
      rd      = 1'b0;
      busy    = 1'b0;
      done    = 1'b0;
      case (state_q)
         IDLE: begin
            if (i_start) state_d = WR_REQ;
         end
         WR_REQ: begin
            wr   = 1'b1;
            busy = 1'b1;
            if (bus.ack)          state_d = GAP;
            else if (tmr_expired) state_d = FINISH;
         end
         RD_REQ: begin
            rd   = 1'b1;
            busy = 1'b1;
            if (bus.ack)          state_d = GAP;
            else if (tmr_expired) state_d = FINISH;
         end
         GAP: begin
            busy = 1'b1;
            if (fin_q)                  state_d = FINISH;
            else if (phase_q == PH_READ) state_d = RD_REQ;
            else                        state_d = WR_REQ;
         end
         FINISH: begin
            done    = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // ---------------- datapath: capture, digit index, sticky flags ----------------
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         phase_q    <= PH_WRITE;
         idx_q      <= '0;
         val_q      <= '0;
         mismatch_q <= 1'b0;
         error_q    <= 1'b0;
         fin_q      <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (i_start) begin
                  val_q      <= i_value;
                  mismatch_q <= 1'b0;
                  error_q    <= 1'b0;
                  idx_q      <= '0;
                  phase_q    <= PH_WRITE;
                  fin_q      <= 1'b0;
               end
            end
            WR_REQ, RD_REQ: begin
               if (bus.ack) begin
                  if (state_q == RD_REQ && bus.rdata[3:0] != cur_nib) mismatch_q <= 1'b1;
                  if (idx_q == LAST_IDX) begin
                     idx_q <= '0;
                     if (state_q == WR_REQ) phase_q <= PH_READ;
                     else                   fin_q   <= 1'b1;
                  end else begin
                     idx_q <= idx_q + IW'(1);
                  end
               end else if (tmr_expired) begin
                  error_q <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // The timer runs only while a strobe is up; idle and gap cycles re-arm it.
   assign tmr_clr = !(wr || rd);
   assign tmr_en  = (wr || rd) && !bus.ack;

   bus_req_timer #(
      .TIMEOUT (TIMEOUT)
   ) u_timer (
      .clk     (clk),
      .n_rst   (n_rst),
      .clr     (tmr_clr),
      .en      (tmr_en),
      .expired (tmr_expired)
   );

   // Request fields are zeroed whenever no strobe is up, so reset drives every output to 0.
   assign bus.wr    = wr;
   assign bus.rd    = rd;
   assign bus.addr  = (wr || rd) ? req_addr : '0;
   assign bus.wdata = wr ? {{(DATA_WIDTH-4){1'b0}}, cur_nib} : '0;

   assign o_busy     = busy;
   assign o_done     = done;
   assign o_mismatch = mismatch_q;
   assign o_error    = error_q;

endmodule

// File: tb/tb_seg7_bus_writer.sv
// Bench for seg7_bus_writer: register-file responder with wait states, corruption and hang
// injection; expected transactions are queued by the stimulus and popped by the bus monitor.
module tb_seg7_bus_writer;

   localparam int          AW   = 32;
   localparam int          DW   = 32;
   localparam int          N    = 8;
   localparam int          TO   = 16;
   localparam logic [31:0] BASE = 32'hc0001000;

   logic          clk = 1'b0;
   logic          n_rst = 1'b0;
   logic          i_start = 1'b0;
   logic [DW-1:0] i_value = '0;
   logic          o_busy, o_done, o_mismatch, o_error;

   seg7_bus_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

   seg7_bus_writer #(
      .ADDR_WIDTH    (AW),
      .DATA_WIDTH    (DW),
      .BASE_ADDR     (BASE),
      .NUM_7SEGMENTS (N),
      .TIMEOUT       (TO)
   ) dut (
      .clk        (clk),
      .n_rst      (n_rst),
      .i_start    (i_start),
      .i_value    (i_value),
      .o_busy     (o_busy),
      .o_done     (o_done),
      .o_mismatch (o_mismatch),
      .o_error    (o_error),
      .bus        (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        wr;
      logic [31:0] addr;
      logic [31:0] data;
   } txn_t;

   txn_t exp_q[$];
   int   vectors = 0;
   int   miscompares = 0;

   // responder configuration
   int          wait_cycles = 0;
   int          corrupt_idx = -1;
   bit          hang_en = 1'b0;
   logic [31:0] hang_addr = '0;
   int          hang_cnt = 0;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   // ---------------- responder + monitor ----------------
   initial begin : responder
      logic [3:0]  mem [N];
      logic        stb, prev_stb, prev_done, done_now;
      logic [31:0] prev_addr, prev_wdata, off;
      logic        prev_wr, prev_rd;
      int          wcnt;
      txn_t        e;
      prev_stb = 0; prev_done = 0; prev_addr = '0; prev_wdata = '0; prev_wr = 0; prev_rd = 0;
      wcnt = 0;
      for (int i = 0; i < N; i++) mem[i] = '0;
      bus.ack = 1'b0;
      bus.rdata = '0;
      forever begin
         @(negedge clk);
         stb = bus.wr | bus.rd;
         if (bus.wr && bus.rd) begin
            vectors++; miscompares++;
            $display("FAIL strobe_exclusive: wr=%b rd=%b both high", bus.wr, bus.rd);
         end
         if (stb && prev_stb && !prev_done) begin
            vectors++;
            if ({bus.addr, bus.wdata, bus.wr, bus.rd} !== {prev_addr, prev_wdata, prev_wr, prev_rd}) begin
               miscompares++;
               $display("FAIL req_stable: got addr=%h wdata=%h wr=%b rd=%b expected addr=%h wdata=%h wr=%b rd=%b",
                        bus.addr, bus.wdata, bus.wr, bus.rd, prev_addr, prev_wdata, prev_wr, prev_rd);
            end
         end
         if (stb && prev_done) begin
            vectors++; miscompares++;
            $display("FAIL strobe_gap: got strobe high right after a completion, expected one low cycle");
         end
         // responder: acks outside a request are random noise the initiator must ignore
         bus.rdata = {$urandom, $urandom} >> 4 << 4;
         off = bus.addr - BASE;
         if (!stb) begin
            wcnt = 0;
            bus.ack = 1'($urandom_range(0, 1));
         end else if (hang_en && bus.addr == hang_addr) begin
            hang_cnt++;
            bus.ack = 1'b0;
         end else if (wcnt < wait_cycles) begin
            wcnt++;
            bus.ack = 1'b0;
         end else begin
            bus.ack = 1'b1;
            if (bus.wr) mem[off[4:2]] = bus.wdata[3:0];
            else if (int'(off[4:2]) == corrupt_idx) bus.rdata[3:0] = 4'h7;
            else bus.rdata[3:0] = mem[off[4:2]];
         end
         // monitor: this cycle's handshake completes at the coming rising edge
         done_now = stb && bus.ack;
         if (done_now) begin
            vectors++;
            if (exp_q.size() == 0) begin
               miscompares++;
               $display("FAIL unexpected_txn: got wr=%b addr=%h, expected no transaction", bus.wr, bus.addr);
            end else begin
               e = exp_q.pop_front();
               if (bus.wr !== e.wr || bus.addr !== e.addr || (e.wr && bus.wdata !== e.data)) begin
                  miscompares++;
                  $display("FAIL txn: got wr=%b addr=%h wdata=%h expected wr=%b addr=%h wdata=%h",
                           bus.wr, bus.addr, bus.wdata, e.wr, e.addr, e.data);
               end
            end
         end
         prev_stb = stb; prev_done = done_now;
         prev_addr = bus.addr; prev_wdata = bus.wdata; prev_wr = bus.wr; prev_rd = bus.rd;
      end
   end

   // ---------------- reference model ----------------
   function automatic logic [31:0] nib(input logic [31:0] v, input int i);
      return (v >> (4 * i)) & 32'hF;
   endfunction

   task automatic build_expect(input logic [31:0] v, input int hang_digit);
      int n_wr;
      n_wr = (hang_digit >= 0) ? hang_digit : N;
      for (int i = 0; i < n_wr; i++) exp_q.push_back('{1'b1, BASE + 32'(4 * i), nib(v, i)});
      if (hang_digit < 0)
         for (int i = 0; i < N; i++) exp_q.push_back('{1'b0, BASE + 32'(4 * i), 32'h0});
   endtask

   task automatic run_op(input logic [31:0] v, input int waits, input int corrupt,
                         input int hang_digit, input bit midstart);
      int cyc, exp_cyc;
      bit got, exp_mm;
      wait_cycles = waits;
      corrupt_idx = corrupt;
      hang_en     = (hang_digit >= 0);
      hang_addr   = BASE + 32'(4 * hang_digit);
      hang_cnt    = 0;
      build_expect(v, hang_digit);
      exp_mm  = (hang_digit < 0 && corrupt >= 0) ? (nib(v, corrupt) != 32'h7) : 1'b0;
      exp_cyc = (hang_digit >= 0) ? (1 + hang_digit * (2 + waits) + TO + 1)
                                  : (2 * N * 2 + 2 + 2 * N * waits);
      @(posedge clk); #1;
      i_start = 1'b1;
      i_value = v;
      cyc = 1;
      got = 0;
      for (int k = 0; k < 3000; k++) begin
         @(posedge clk); #1;
         cyc++;
         if (cyc == 2) begin
            i_start = 1'b0;
            i_value = $urandom;
            chk("busy_after_start", o_busy, 1);
         end
         if (midstart && cyc == 12) begin i_start = 1'b1; i_value = ~v; end
         if (midstart && cyc == 13) i_start = 1'b0;
         if (o_done) begin got = 1; break; end
      end
      vectors++;
      if (!got) begin
         miscompares++;
         $display("FAIL done_timeout: got no o_done within 3000 cycles, expected at cycle %0d", exp_cyc);
      end else begin
         chk("done_cycle", cyc, exp_cyc);
         chk("busy_at_done", o_busy, 0);
         chk("mismatch_flag", o_mismatch, exp_mm);
         chk("error_flag", o_error, hang_digit >= 0);
         @(posedge clk); #1;
         chk("done_one_cycle", o_done, 0);
         chk("mismatch_sticky", o_mismatch, exp_mm);
      end
      chk("txn_queue_empty", exp_q.size(), 0);
      if (hang_digit >= 0) chk("hang_strobe_cycles", hang_cnt, TO);
      hang_en = 1'b0;
      exp_q.delete();
   endtask

   // ---------------- stimulus ----------------
   initial begin : stimulus
      logic [31:0] v;
      int          c;
      bit          found;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_status", {o_busy, o_done, o_mismatch, o_error, bus.wr, bus.rd}, 0);
      chk("rst_addr", bus.addr, 0);
      chk("rst_wdata", bus.wdata, 0);
      @(negedge clk);
      n_rst = 1'b1;

      run_op(32'h1234abcd, 0, -1, -1, 0);   // zero-wait, done at cycle 34
      run_op(32'h1234abcd, 3, -1, -1, 0);   // 3 waits per request, done at cycle 82
      run_op(32'h1234abcd, 0, 5, -1, 0);    // digit 5 reads back 7 instead of 3
      run_op(32'h1234abcd, 0, -1, 2, 0);    // write to c0001008 never acked

      // reset in idle clears the sticky error
      @(posedge clk); #1;
      n_rst = 1'b0;
      #1;
      chk("idle_rst_error", o_error, 0);
      @(negedge clk);
      n_rst = 1'b1;

      run_op($urandom, 1, -1, -1, 1);       // second start mid-run is ignored

      // reset during the write of digit 2
      wait_cycles = 3; corrupt_idx = -1; hang_en = 1'b0;
      v = $urandom;
      build_expect(v, -1);
      @(posedge clk); #1;
      i_start = 1'b1;
      i_value = v;
      found = 0;
      for (int k = 0; k < 500; k++) begin
         @(posedge clk); #1;
         i_start = 1'b0;
         if (bus.wr && bus.addr == BASE + 32'h8) begin found = 1; break; end
      end
      chk("reach_digit2_write", found, 1);
      n_rst = 1'b0;
      #1;
      chk("midrst_status", {o_busy, o_done, o_mismatch, o_error, bus.wr, bus.rd}, 0);
      chk("midrst_addr", bus.addr, 0);
      chk("midrst_wdata", bus.wdata, 0);
      exp_q.delete();
      repeat (2) begin
         @(posedge clk); #1;
         chk("midrst_no_done", o_done, 0);
      end
      @(negedge clk);
      n_rst = 1'b1;
      repeat (2) begin
         @(posedge clk); #1;
         chk("postrst_idle", {o_busy, o_done, bus.wr, bus.rd}, 0);
      end

      run_op(32'h0, 0, -1, -1, 0);          // all-zero digits

      for (int r = 0; r < 6; r++) begin
         c = $urandom_range(0, 8);
         run_op($urandom, $urandom_range(0, 3), (c == 8) ? -1 : c, -1, 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation still running after 50000 cycles");
      $fatal(1);
   end

endmodule
